// File: rtl/q2a03_bus_responder.sv
// q2a03_bus_responder: bus-side responder for the Q2A03 CPU core.
// Serves a 2 KiB work RAM mirrored over $0000-$1FFF and forwards every
// other address to an external request/acknowledge port. Writes to the
// external side are posted through a small buffer. External reads stall
// the CPU via G_ready until X_ack arrives or the read times out.
//
// Ports:
//   G_clock, G_reset   master clock, async active-low reset
//   G_phy2             CPU phase-2 strobe
//   G_addr/G_rdwr      CPU address, 1 = read / 0 = write
//   G_wr_data/G_sync   CPU write data, opcode-fetch marker
//   G_rd_data/G_ready  read data and cycle-complete flag back to the CPU
//   X_req/X_we/X_addr/X_wdata/X_rdata/X_ack   external req/ack port
//   err_timeout/err_wovf   sticky error flags
//   fetch_count        wrapping count of completed opcode fetches
module q2a03_bus_responder #(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned EXT_TIMEOUT = 64,
    parameter int unsigned WBUF_DEPTH  = 2
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    input  logic        G_sync,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        X_req,
    output logic        X_we,
    output logic [15:0] X_addr,
    output logic [7:0]  X_wdata,
    input  logic [7:0]  X_rdata,
    input  logic        X_ack,
    output logic        err_timeout,
    output logic        err_wovf,
    output logic [15:0] fetch_count
);
    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam int unsigned WB_AW     = $clog2(WBUF_DEPTH);
    localparam int unsigned WB_CW     = WB_AW + 1;
    localparam int unsigned TMO_W     = $clog2(EXT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RAM_RD,
        EXT_DRAIN,
        EXT_RD,
        DONE
    } state_t;

    state_t            state_q;
    logic              phy2_q;
    logic [7:0]        rd_data_q;
    logic              ready_q;
    logic              x_req_q;
    logic              x_we_q;
    logic [15:0]       x_addr_q;
    logic [7:0]        x_wdata_q;
    logic              err_timeout_q;
    logic              err_wovf_q;
    logic [15:0]       fetch_q;
    logic [7:0]        ob_q;
    logic [15:0]       rd_addr_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [15:0]       wb_addr_q [WBUF_DEPTH];
    logic [7:0]        wb_data_q [WBUF_DEPTH];
    logic [WB_AW-1:0]  wb_wr_ptr_q;
    logic [WB_AW-1:0]  wb_rd_ptr_q;
    logic [WB_CW-1:0]  wb_cnt_q;

    logic [7:0]        mem [RAM_WORDS];

    logic              rise;
    logic              fall;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_wr;
    logic              ext_wr;
    logic              wb_full;
    logic              wb_empty;
    logic              push;
    logic              ack_ok;
    logic              pop;
    logic              start_wr;

    assign rise     = G_phy2 & ~phy2_q;
    assign fall     = ~G_phy2 & phy2_q;
    assign ram_hit  = (G_addr[15:13] == 3'b000);
    assign ram_idx  = G_addr[RAM_AW-1:0];
    assign ram_wr   = fall & ~G_rdwr & ram_hit;
    assign ext_wr   = fall & ~G_rdwr & ~ram_hit;
    assign wb_full  = (wb_cnt_q == WB_CW'(WBUF_DEPTH));
    assign wb_empty = (wb_cnt_q == '0);
    assign push     = ext_wr & ~wb_full;
    // An ack only counts while a request is actually outstanding.
    assign ack_ok   = x_req_q & X_ack;
    assign pop      = ack_ok & x_we_q;
    // Posted writes drain whenever the port is free and no read owns it.
    assign start_wr = ~x_req_q & ~wb_empty & (state_q != EXT_RD);

    // Work RAM write port; contents deliberately survive reset.
    always_ff @(posedge G_clock) begin
        if (ram_wr) begin
            mem[ram_idx] <= G_wr_data;
        end
    end

    // Control FSM, posted-write buffer and external port.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state_q       <= IDLE;
            phy2_q        <= 1'b0;
            rd_data_q     <= 8'h00;
            ready_q       <= 1'b1;
            x_req_q       <= 1'b0;
            x_we_q        <= 1'b0;
            x_addr_q      <= 16'h0000;
            x_wdata_q     <= 8'h00;
            err_timeout_q <= 1'b0;
            err_wovf_q    <= 1'b0;
            fetch_q       <= 16'h0000;
            ob_q          <= 8'h00;
            rd_addr_q     <= 16'h0000;
            tmo_q         <= '0;
            wb_wr_ptr_q   <= '0;
            wb_rd_ptr_q   <= '0;
            wb_cnt_q      <= '0;
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                wb_addr_q[i] <= 16'h0000;
                wb_data_q[i] <= 8'h00;
            end
        end else begin
            phy2_q <= G_phy2;

            // A stalled fetch is counted once, on the fall that completes it.
            if (fall && G_sync && ready_q) begin
                fetch_q <= fetch_q + 16'd1;
            end

            if (push) begin
                wb_addr_q[wb_wr_ptr_q] <= G_addr;
                wb_data_q[wb_wr_ptr_q] <= G_wr_data;
                wb_wr_ptr_q            <= wb_wr_ptr_q + WB_AW'(1);
            end
            if (ext_wr && wb_full) begin
                err_wovf_q <= 1'b1;
            end
            if (pop) begin
                wb_rd_ptr_q <= wb_rd_ptr_q + WB_AW'(1);
            end
            wb_cnt_q <= wb_cnt_q + WB_CW'(push) - WB_CW'(pop);

            if (ack_ok) begin
                x_req_q <= 1'b0;
                if (x_we_q) begin
                    ob_q <= x_wdata_q;
                end
            end else if (start_wr) begin
                x_req_q   <= 1'b1;
                x_we_q    <= 1'b1;
                x_addr_q  <= wb_addr_q[wb_rd_ptr_q];
                x_wdata_q <= wb_data_q[wb_rd_ptr_q];
            end

            case (state_q)
                IDLE: begin
                    if (rise && G_rdwr) begin
                        if (ram_hit) begin
                            state_q   <= RAM_RD;
                            rd_data_q <= mem[ram_idx];
                            ob_q      <= mem[ram_idx];
                        end else begin
                            rd_addr_q <= G_addr;
                            ready_q   <= 1'b0;
                            // Reads never overtake posted writes.
                            if (!wb_empty) begin
                                state_q <= EXT_DRAIN;
                            end else begin
                                state_q  <= EXT_RD;
                                x_req_q  <= 1'b1;
                                x_we_q   <= 1'b0;
                                x_addr_q <= G_addr;
                                tmo_q    <= '0;
                            end
                        end
                    end
                end
                RAM_RD: begin
                    state_q <= DONE;
                end
                EXT_DRAIN: begin
                    if (wb_empty && !x_req_q) begin
                        state_q  <= EXT_RD;
                        x_req_q  <= 1'b1;
                        x_we_q   <= 1'b0;
                        x_addr_q <= rd_addr_q;
                        tmo_q    <= '0;
                    end
                end
                EXT_RD: begin
                    if (ack_ok) begin
                        rd_data_q <= X_rdata;
                        ob_q      <= X_rdata;
                        ready_q   <= 1'b1;
                        state_q   <= DONE;
                    end else if (tmo_q == TMO_W'(EXT_TIMEOUT - 1)) begin
                        // Abandoned read returns the open-bus value.
                        x_req_q       <= 1'b0;
                        ready_q       <= 1'b1;
                        rd_data_q     <= ob_q;
                        err_timeout_q <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    if (fall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (ram_wr) begin
                ob_q <= G_wr_data;
            end
        end
    end

    assign G_rd_data   = rd_data_q;
    assign G_ready     = ready_q;
    assign X_req       = x_req_q;
    assign X_we        = x_we_q;
    assign X_addr      = x_addr_q;
    assign X_wdata     = x_wdata_q;
    assign err_timeout = err_timeout_q;
    assign err_wovf    = err_wovf_q;
    assign fetch_count = fetch_q;

endmodule

// File: tb/tb_q2a03_bus_responder.sv
// tb_q2a03_bus_responder: directed bench for q2a03_bus_responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_q2a03_bus_responder;
    logic        G_clock   = 1'b0;
    logic        G_reset   = 1'b1;
    logic        G_phy2    = 1'b0;
    logic [15:0] G_addr    = 16'h0000;
    logic        G_rdwr    = 1'b1;
    logic [7:0]  G_wr_data = 8'h00;
    logic        G_sync    = 1'b0;
    logic [7:0]  G_rd_data;
    logic        G_ready;
    logic        X_req;
    logic        X_we;
    logic [15:0] X_addr;
    logic [7:0]  X_wdata;
    logic [7:0]  X_rdata   = 8'h00;
    logic        X_ack     = 1'b0;
    logic        err_timeout;
    logic        err_wovf;
    logic [15:0] fetch_count;

    int n_cmp  = 0;
    int n_fail = 0;

    q2a03_bus_responder dut (
        .G_clock     (G_clock),
        .G_reset     (G_reset),
        .G_phy2      (G_phy2),
        .G_addr      (G_addr),
        .G_rdwr      (G_rdwr),
        .G_wr_data   (G_wr_data),
        .G_sync      (G_sync),
        .G_rd_data   (G_rd_data),
        .G_ready     (G_ready),
        .X_req       (X_req),
        .X_we        (X_we),
        .X_addr      (X_addr),
        .X_wdata     (X_wdata),
        .X_rdata     (X_rdata),
        .X_ack       (X_ack),
        .err_timeout (err_timeout),
        .err_wovf    (err_wovf),
        .fetch_count (fetch_count)
    );

    always #5 G_clock = ~G_clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge G_clock);
    endtask

    task automatic phase_low(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic sy);
        G_addr    = a;
        G_rdwr    = rw;
        G_wr_data = wd;
        G_sync    = sy;
        G_phy2    = 1'b0;
        repeat (5) tick();
    endtask

    task automatic phase_high(input int n);
        G_phy2 = 1'b1;
        repeat (n) tick();
    endtask

    // Drop phy2 while still holding address/data so the fall sees them.
    task automatic end_cycle();
        G_phy2 = 1'b0;
        tick();
    endtask

    task automatic write_cycle(input logic [15:0] a, input logic [7:0] d);
        phase_low(a, 1'b0, d, 1'b0);
        phase_high(6);
        end_cycle();
    endtask

    // Wait (bounded) for X_req, check the request, answer with a one-cycle ack.
    task automatic ack_when_req(input string tag, input logic [15:0] ea, input logic ewe,
                                input logic [7:0] ewd, input logic [7:0] rdata);
        int waited = 0;
        while (X_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " req"}, 16'(X_req), 16'h0001);
        if (X_req === 1'b1) begin
            check({tag, " addr"}, X_addr, ea);
            check({tag, " we"}, 16'(X_we), 16'(ewe));
            if (ewe) check({tag, " wdata"}, 16'(X_wdata), 16'(ewd));
            X_rdata = rdata;
            X_ack   = 1'b1;
            tick();
            X_ack   = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 G_reset = 1'b0;
        repeat (2) tick();
        check("rst rd_data", 16'(G_rd_data), 16'h0000);
        check("rst ready", 16'(G_ready), 16'h0001);
        check("rst x_req", 16'(X_req), 16'h0000);
        check("rst x_we", 16'(X_we), 16'h0000);
        check("rst x_addr", X_addr, 16'h0000);
        check("rst x_wdata", 16'(X_wdata), 16'h0000);
        check("rst err_to", 16'(err_timeout), 16'h0000);
        check("rst err_wovf", 16'(err_wovf), 16'h0000);
        check("rst fetch", fetch_count, 16'h0000);
        G_reset = 1'b1;
        tick();

        // RAM write then mirrored read
        write_cycle(16'h0005, 8'hA5);
        check("t1 wr ready", 16'(G_ready), 16'h0001);
        phase_low(16'h1805, 1'b1, 8'h00, 1'b1);
        phase_high(1);
        check("t1 rd data", 16'(G_rd_data), 16'h00A5);
        check("t1 rd ready", 16'(G_ready), 16'h0001);
        phase_high(5);
        check("t1 ready late", 16'(G_ready), 16'h0001);
        check("t1 no xreq", 16'(X_req), 16'h0000);
        end_cycle();
        check("t1 held data", 16'(G_rd_data), 16'h00A5);
        check("t1 fetch", fetch_count, 16'h0001);

        // External read, ack 5 clocks after X_req
        phase_low(16'h8000, 1'b1, 8'h00, 1'b1);
        phase_high(1);
        check("t2 req", 16'(X_req), 16'h0001);
        check("t2 we", 16'(X_we), 16'h0000);
        check("t2 addr", X_addr, 16'h8000);
        check("t2 ready0", 16'(G_ready), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2 stall", 16'(G_ready), 16'h0000);
        end
        X_rdata = 8'h3C;
        X_ack   = 1'b1;
        tick();
        X_ack   = 1'b0;
        check("t2 ready1", 16'(G_ready), 16'h0001);
        check("t2 data", 16'(G_rd_data), 16'h003C);
        check("t2 req drop", 16'(X_req), 16'h0000);
        check("t2 fetch hold", fetch_count, 16'h0001);
        end_cycle();
        check("t2 fetch once", fetch_count, 16'h0002);
        check("t2 done ready", 16'(G_ready), 16'h0001);

        // Posted writes drain in order before a following read
        write_cycle(16'h4014, 8'h02);
        write_cycle(16'h4015, 8'h07);
        check("t3 no wovf", 16'(err_wovf), 16'h0000);
        phase_low(16'h4016, 1'b1, 8'h00, 1'b0);
        phase_high(1);
        check("t3 ready0", 16'(G_ready), 16'h0000);
        ack_when_req("t3 w0", 16'h4014, 1'b1, 8'h02, 8'h00);
        check("t3 ready mid", 16'(G_ready), 16'h0000);
        ack_when_req("t3 w1", 16'h4015, 1'b1, 8'h07, 8'h00);
        check("t3 ready pre", 16'(G_ready), 16'h0000);
        ack_when_req("t3 rd", 16'h4016, 1'b0, 8'h00, 8'h99);
        check("t3 ready1", 16'(G_ready), 16'h0001);
        check("t3 data", 16'(G_rd_data), 16'h0099);
        end_cycle();

        // Write buffer overflow with no acks
        write_cycle(16'h6000, 8'h11);
        write_cycle(16'h6000, 8'h22);
        check("t4 wovf0", 16'(err_wovf), 16'h0000);
        write_cycle(16'h6000, 8'h33);
        check("t4 wovf1", 16'(err_wovf), 16'h0001);
        ack_when_req("t4 e0", 16'h6000, 1'b1, 8'h11, 8'h00);
        ack_when_req("t4 e1", 16'h6000, 1'b1, 8'h22, 8'h00);
        repeat (3) tick();
        check("t4 empty", 16'(X_req), 16'h0000);
        X_ack = 1'b1;
        tick();
        X_ack = 1'b0;
        tick();
        check("t4 stray ack req", 16'(X_req), 16'h0000);
        check("t4 stray ack data", 16'(G_rd_data), 16'h0099);

        // External read timeout returns open-bus byte
        write_cycle(16'h0010, 8'h5A);
        phase_low(16'h0010, 1'b1, 8'h00, 1'b0);
        phase_high(6);
        check("t5 ram data", 16'(G_rd_data), 16'h005A);
        end_cycle();
        phase_low(16'hC000, 1'b1, 8'h00, 1'b0);
        phase_high(1);
        check("t5 req", 16'(X_req), 16'h0001);
        check("t5 ready0", 16'(G_ready), 16'h0000);
        repeat (63) tick();
        check("t5 ready63", 16'(G_ready), 16'h0000);
        check("t5 req63", 16'(X_req), 16'h0001);
        check("t5 err63", 16'(err_timeout), 16'h0000);
        tick();
        check("t5 ready64", 16'(G_ready), 16'h0001);
        check("t5 req64", 16'(X_req), 16'h0000);
        check("t5 data", 16'(G_rd_data), 16'h005A);
        check("t5 err", 16'(err_timeout), 16'h0001);
        end_cycle();

        // Reset in the middle of an external read
        phase_low(16'h8001, 1'b1, 8'h00, 1'b0);
        phase_high(1);
        check("t6 req", 16'(X_req), 16'h0001);
        repeat (2) tick();
        G_reset = 1'b0;
        #1;
        check("t6 rst req", 16'(X_req), 16'h0000);
        check("t6 rst ready", 16'(G_ready), 16'h0001);
        check("t6 rst data", 16'(G_rd_data), 16'h0000);
        check("t6 rst err_to", 16'(err_timeout), 16'h0000);
        check("t6 rst err_wovf", 16'(err_wovf), 16'h0000);
        tick();
        G_phy2  = 1'b0;
        G_reset = 1'b1;
        tick();
        X_rdata = 8'hEE;
        X_ack   = 1'b1;
        tick();
        X_ack   = 1'b0;
        check("t6 late ack req", 16'(X_req), 16'h0000);
        check("t6 late ack data", 16'(G_rd_data), 16'h0000);
        check("t6 late ack ready", 16'(G_ready), 16'h0001);
        phase_low(16'h0010, 1'b1, 8'h00, 1'b1);
        phase_high(6);
        check("t6 ram kept", 16'(G_rd_data), 16'h005A);
        end_cycle();
        check("t6 fetch", fetch_count, 16'h0001);

        // Decode boundaries: $1FFF mirrors index $7FF, $2000 is external
        write_cycle(16'h1FFF, 8'h77);
        phase_low(16'h07FF, 1'b1, 8'h00, 1'b0);
        phase_high(6);
        check("b 1fff data", 16'(G_rd_data), 16'h0077);
        check("b 1fff no req", 16'(X_req), 16'h0000);
        end_cycle();
        phase_low(16'h2000, 1'b1, 8'h00, 1'b0);
        phase_high(1);
        check("b 2000 ready0", 16'(G_ready), 16'h0000);
        ack_when_req("b 2000", 16'h2000, 1'b0, 8'h00, 8'h42);
        check("b 2000 data", 16'(G_rd_data), 16'h0042);
        check("b 2000 ready1", 16'(G_ready), 16'h0001);
        end_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/q2a03_bus_responder.md
Name: q2a03_bus_responder

Overview:
- Bus-side responder for the Q2A03 CPU core. It answers every CPU bus cycle defined by G_phy2, G_addr, G_rdwr and G_wr_data, and drives G_rd_data and G_ready.
- Serves reads and writes to an internal 2 KiB work RAM mirrored over $0000-$1FFF.
- Forwards all other addresses to an external request/acknowledge port, stalling CPU reads via G_ready until the data arrives.
- Sits between the CPU core and the cartridge/PPU/APU fabric in the top level.

Parameters:
- RAM_AW, 11, internal RAM address width (2^RAM_AW bytes, mirrored across $0000-$1FFF).
- EXT_TIMEOUT, 64, G_clock cycles an external read may wait for X_ack before it is abandoned.
- WBUF_DEPTH, 2, posted external write buffer entries (power of two, >=2).

Ports:
- G_clock  in  1  master clock; same clock that drives the CPU core.
- G_reset  in  1  asynchronous, active-low reset.
- G_phy2  in  1  CPU phase-2 strobe (high 6 of 12 G_clock ticks).
- G_addr  in  16  CPU address.
- G_rdwr  in  1  1 = read, 0 = write.
- G_wr_data  in  8  CPU write data.
- G_sync  in  1  opcode fetch marker; only used for the fetch counter.
- G_rd_data  out  8  read data to the CPU.
- G_ready  out  1  1 = cycle may complete; 0 = CPU holds the current read cycle.
- X_req  out  1  external request; held until X_ack.
- X_we  out  1  external write enable; valid with X_req.
- X_addr  out  16  external address.
- X_wdata  out  8  external write data.
- X_rdata  in  8  external read data; valid when X_ack.
- X_ack  in  1  external completion, one-cycle pulse.
- err_timeout  out  1  sticky; set when an external read times out.
- err_wovf  out  1  sticky; set when a write is dropped on a full buffer.
- fetch_count  out  16  count of G_sync-qualified opcode fetches, wraps.

Behaviour:
- Reset (G_reset=0, async): G_rd_data=8'h00, G_ready=1, X_req=0, X_we=0, X_addr=0, X_wdata=0, err_*=0, fetch_count=0, FSM=IDLE, write buffer empty, open-bus latch=8'h00. RAM contents are not reset. Reset asserted mid-access drops X_req immediately; a late X_ack after reset is ignored.
- Edge detection: register phy2_q each G_clock. rise = G_phy2 & ~phy2_q; fall = ~G_phy2 & phy2_q.
- Decode at rise: RAM hit when G_addr[15:13]==0, RAM index G_addr[RAM_AW-1:0]. Every other address is an EXT access.
- FSM states: IDLE, RAM_RD, EXT_DRAIN, EXT_RD, DONE.
- IDLE + rise + read + RAM -> RAM_RD. Synchronous RAM; G_rd_data is valid 1 clock after rise and held until the next rise.
- IDLE + rise + read + EXT:
  - Write buffer non-empty -> EXT_DRAIN, G_ready=0. Reads never bypass posted writes.
  - Otherwise -> EXT_RD: X_req=1, X_we=0, X_addr=G_addr, G_ready=0 in the same clock as the transition.
- EXT_DRAIN: when the buffer becomes empty -> EXT_RD.
- EXT_RD + X_ack:
  - Latch X_rdata into G_rd_data and the open-bus latch.
  - X_req=0, G_ready=1, -> DONE.
- EXT_RD timeout: counter starts at X_req assertion. At EXT_TIMEOUT cycles without X_ack:
  - X_req=0, G_ready=1, G_rd_data=open-bus latch, err_timeout=1, -> DONE.
- DONE -> IDLE at the next fall.
- Stall rule: while G_ready=0 the CPU repeats the identical read cycle. Further rise edges are ignored until DONE.
- Writes ignore G_ready and never stall.
  - RAM write: commits G_wr_data at fall.
  - EXT write: pushes {G_addr, G_wr_data} into the buffer at fall.
- Write buffer full at fall: the write is dropped, err_wovf=1, and the buffer is unchanged.
- Buffer drain, independent of the FSM when not in EXT_RD:
  - Head entry drives X_req=1, X_we=1, X_addr, X_wdata.
  - Pop on X_ack.
  - Open-bus latch also takes X_wdata and any RAM-written byte.
- Open-bus latch: updated with RAM read data and every value G_rd_data ever drives.
- fetch_count increments at fall when G_sync=1 (including stalled fetches, counted once at completion), modulo 2^16.
- X_ack arriving while X_req=0 is ignored.

Test Plan:
- Write 8'hA5 to $0005, then read $1805 (mirror) -> G_rd_data=8'hA5 before the next fall; G_ready stays 1 throughout.
- Read $8000 with X_ack 5 clocks after X_req and X_rdata=8'h3C -> G_ready low 5 clocks, then G_rd_data=8'h3C, X_req drops with X_ack, CPU cycle completes.
- Two back-to-back writes to $4014/$4015 (8'h02, 8'h07), then read $4016 -> X sees two writes in order, then the read; G_ready=0 until the read ack.
- Three writes to $6000 with X_ack tied 0 -> third write dropped, err_wovf=1, buffer holds the first two.
- Read $C000 with no X_ack after prior RAM read of 8'h5A -> after 64 clocks G_ready=1, G_rd_data=8'h5A, err_timeout=1.
- Pull G_reset low during EXT_RD -> X_req=0, G_ready=1, G_rd_data=0 immediately; a late X_ack is ignored; normal reads resume after release.
